// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM controller port between VGA, CPU data and CPU fetch.
// Bounded VGA priority, per-transaction timeout, sticky timeout flag.
module mem_bus_arbiter #(
  parameter int TIMEOUT       = 64,
  parameter int VGA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        v_req,
  input  logic [31:0] v_addr,
  output logic        v_ack,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output logic        cpu_stall,
  output logic        timeout_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RW = $clog2(VGA_BURST_MAX + 1);
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t        state;
  logic [2:0]    gnt;
  logic [2:0]    pick;
  logic [CW-1:0] cnt;
  logic [RW-1:0] vga_run;
  logic          cpu_turn;
  logic [31:0]   sel_addr;

  // Bit order of pick/gnt: [0] VGA, [1] data, [2] fetch.
  always_comb begin
    pick     = 3'b000;
    cpu_turn = (vga_run == RW'(VGA_BURST_MAX)) && (d_req || i_req);
    if (cpu_turn)   pick = d_req ? 3'b010 : 3'b100;
    else if (v_req) pick = 3'b001;
    else if (d_req) pick = 3'b010;
    else if (i_req) pick = 3'b100;
  end

  always_comb begin
    sel_addr = '0;
    unique case (1'b1)
      pick[0]: sel_addr = v_addr;
      pick[1]: sel_addr = d_addr;
      pick[2]: sel_addr = i_addr;
      default: sel_addr = '0;
    endcase
  end

  assign cpu_stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      cnt         <= '0;
      vga_run     <= '0;
      v_ack       <= 1'b0;
      d_ack       <= 1'b0;
      i_ack       <= 1'b0;
      rdata       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|pick) begin
            gnt       <= pick;
            mem_req   <= 1'b1;
            mem_addr  <= sel_addr;
            mem_we    <= pick[1] & d_we;
            mem_wdata <= pick[1] ? d_wdata : '0;
            cnt       <= '0;
            state     <= BUSY;
            if (!pick[0])
              vga_run <= '0;
            else if (vga_run != RW'(VGA_BURST_MAX))
              vga_run <= vga_run + 1'b1;
          end
        end
        BUSY: begin
          if (mem_done) begin
            mem_req               <= 1'b0;
            {i_ack, d_ack, v_ack} <= gnt;
            if (!mem_we) rdata    <= mem_rdata;
            state                 <= ACK;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            mem_req               <= 1'b0;
            {i_ack, d_ack, v_ack} <= gnt;
            if (!mem_we) rdata    <= BAD;
            timeout_err           <= 1'b1;
            state                 <= ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK: begin
          // Requester still holds req this cycle; no grant here.
          {i_ack, d_ack, v_ack} <= 3'b000;
          state                 <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_mem_bus_arbiter;

  localparam int TO = 64;
  localparam int VB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int v_cnt = 0, d_cnt = 0, i_cnt = 0;
  logic v_req, d_req, i_req;
  assign v_req = (v_cnt > 0);
  assign d_req = (d_cnt > 0);
  assign i_req = (i_cnt > 0);

  logic [31:0] v_addr = 32'h1000, i_addr = 0, d_addr = 0, d_wdata = 0;
  logic        d_we = 1'b0;
  logic        v_ack, d_ack, i_ack;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        mem_req, mem_we, mem_done, cpu_stall, timeout_err;

  logic ctl_en = 1'b1, ctl_done = 1'b0, stray = 1'b0;
  int   ctl_delay = 0;
  assign mem_done = ctl_done | stray;

  int          busy_n = 0, req_cyc = 0;
  logic [31:0] cap_addr = 0, cap_wdata = 0;
  logic        cap_we = 0;
  string       aq = "";
  int          nvec = 0, nfail = 0;

  mem_bus_arbiter #(.TIMEOUT(TO), .VGA_BURST_MAX(VB)) dut (
    .clk(clk), .rst(rst),
    .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done),
    .cpu_stall(cpu_stall), .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chks(input string nm, input string act, input string exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got '%s' want '%s'", nm, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 waiting on controller, 2 ack; who 0=v 1=d 2=i
  int          m_phase = 0, m_who = 0, m_run = 0, m_busy = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic        m_we = 0, m_req = 0, m_err = 0;
  logic [2:0]  m_ack = 0;

  task automatic finish_txn(input logic [31:0] rd, input logic tmo);
    m_req = 1'b0;
    m_ack = 3'b001 << m_who;
    if (!m_we) m_rdata = rd;
    if (tmo) m_err = 1'b1;
    m_phase = 2;
  endtask

  task automatic model_step();
    bit cpu_turn;
    if (rst) begin
      m_phase = 0; m_run = 0; m_busy = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0;
      m_we = 0; m_req = 0; m_err = 0; m_ack = 0;
    end else begin
      case (m_phase)
        0: begin
          cpu_turn = (m_run == VB) && (d_req || i_req);
          if (v_req || d_req || i_req) begin
            if (cpu_turn)   m_who = d_req ? 1 : 2;
            else if (v_req) m_who = 0;
            else if (d_req) m_who = 1;
            else            m_who = 2;
            m_addr  = (m_who == 0) ? v_addr : (m_who == 1) ? d_addr : i_addr;
            m_we    = (m_who == 1) && d_we;
            m_wdata = (m_who == 1) ? d_wdata : 32'h0;
            m_req   = 1'b1;
            m_busy  = 0;
            m_phase = 1;
            if (m_who == 0) m_run = (m_run < VB) ? m_run + 1 : VB;
            else            m_run = 0;
          end
        end
        1: begin
          m_busy++;
          if (mem_done)          finish_txn(mem_rdata, 1'b0);
          else if (m_busy == TO) finish_txn(32'hDEADBEEF, 1'b1);
        end
        default: begin
          m_ack   = 3'b000;
          m_phase = 0;
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    chk("mem_req",   mem_req,   m_req);
    chk("mem_we",    mem_we,    m_we);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("acks",      {i_ack, d_ack, v_ack}, m_ack);
    chk("rdata",     rdata,     m_rdata);
    chk("tmo_err",   timeout_err, m_err);
    chk("cpu_stall", cpu_stall,
        (i_req & ~m_ack[2]) | (d_req & ~m_ack[1]));
  end

  // Requesters and controller, all driven on the falling edge
  initial forever begin
    @(negedge clk);
    if (v_ack) begin
      if (v_cnt > 0) v_cnt--;
      v_addr += 4;
      aq = {aq, "v"};
    end
    if (d_ack) begin
      if (d_cnt > 0) d_cnt--;
      aq = {aq, "d"};
    end
    if (i_ack) begin
      if (i_cnt > 0) i_cnt--;
      aq = {aq, "i"};
    end
    if (mem_req) req_cyc++;
    if (ctl_en && mem_req) begin
      if (busy_n == 0) begin
        cap_addr  = mem_addr;
        cap_we    = mem_we;
        cap_wdata = mem_wdata;
      end
      ctl_done = (busy_n >= ctl_delay);
      busy_n++;
    end else begin
      ctl_done = 1'b0;
      busy_n   = 0;
    end
  end

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (n < budget && (v_cnt > 0 || d_cnt > 0 || i_cnt > 0)) begin
      @(negedge clk); #2;
      n++;
    end
    if (v_cnt > 0 || d_cnt > 0 || i_cnt > 0) begin
      nvec++; nfail++;
      $display("FAIL %s: no completion after %0d cycles", nm, budget);
      v_cnt = 0; d_cnt = 0; i_cnt = 0;
    end
    repeat (3) @(negedge clk);
    #2;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk); #2;

    // Single data read, controller answers in first busy cycle
    d_addr = 32'h100; d_we = 0; mem_rdata = 32'hCAFEF00D; ctl_delay = 0;
    d_cnt = 1;
    #1;
    chk("rd_stall_pend", cpu_stall, 1);
    n = 0;
    while (!d_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rd_latency", n, 2);
    chk("rd_rdata", rdata, 32'hCAFEF00D);
    chk("rd_addr", cap_addr, 32'h100);
    chk("rd_we", cap_we, 0);
    wait_idle("rd", 20);

    // All three at once
    aq = ""; mem_rdata = 32'h11111111;
    v_cnt = 1; d_cnt = 1; i_cnt = 1;
    wait_idle("all3", 40);
    chks("all3_order", aq, "vdi");

    // VGA flood with data pending
    aq = "";
    v_cnt = 9; d_cnt = 2;
    wait_idle("flood", 200);
    chks("flood_order", aq, "vvvvdvvvvdv");

    // Data write, slower controller
    aq = ""; d_we = 1; d_wdata = 32'h12345678; d_addr = 32'h300;
    ctl_delay = 3; mem_rdata = 32'h55555555;
    d_cnt = 1;
    wait_idle("wr", 40);
    chks("wr_acks", aq, "d");
    chk("wr_we", cap_we, 1);
    chk("wr_wdata", cap_wdata, 32'h12345678);
    chk("wr_rdata_kept", rdata, 32'h11111111);
    d_we = 0; ctl_delay = 0;

    // Fetch that never completes
    aq = ""; ctl_en = 0; i_addr = 32'h40; req_cyc = 0;
    i_cnt = 1;
    wait_idle("tmo", 120);
    chks("tmo_acks", aq, "i");
    chk("tmo_cycles", req_cyc, 64);
    chk("tmo_rdata", rdata, 32'hDEADBEEF);
    chk("tmo_err_set", timeout_err, 1);
    ctl_en = 1; mem_rdata = 32'h0BADCAFE;
    v_cnt = 1;
    wait_idle("post_tmo", 20);
    chk("tmo_err_sticky", timeout_err, 1);
    chk("post_tmo_rdata", rdata, 32'h0BADCAFE);

    // Reset during a pending transaction, then a stray done
    aq = ""; ctl_en = 0; d_addr = 32'h200;
    d_cnt = 1;
    repeat (5) @(negedge clk);
    #2;
    chk("pre_rst_req", mem_req, 1);
    rst = 1'b1; d_cnt = 0;
    @(negedge clk); #2;
    rst = 1'b0;
    chk("rst_busy_req", mem_req, 0);
    chk("rst_busy_addr", mem_addr, 0);
    chk("rst_busy_err", timeout_err, 0);
    stray = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    stray = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chks("rst_no_ack", aq, "");
    chk("rst_idle_req", mem_req, 0);
    ctl_en = 1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
